// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sequencer
// Description : Phase sequencer for the CSCv2 ROM-decoded datapath. Owns the
//               program counter and NZVC flags, steps each instruction through
//               FETCH / EXEC / WRITE, drives the active-low top ROM enable,
//               gates ROM control outputs into single-cycle write strobes and
//               detects the jump-to-self halt idiom.
// Options     : SINGLESTEP_EN - adds a 'step' input; one rising edge of step
//               in IDLE executes exactly one instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
`ifdef SINGLESTEP_EN
  input  logic       step,
`endif
  input  logic       ctl_pcincr,
  input  logic       ctl_aload,
  input  logic       ctl_bload,
  input  logic       ctl_ramwrite,
  input  logic [7:0] jump_addr,
  input  logic [3:0] alu_nzvc,
  output logic [7:0] PC,
  output logic [3:0] NZVC,
  output logic       rom_en_n,
  output logic       a_we,
  output logic       b_we,
  output logic       ram_we,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_pc;
  logic [3:0] r_nzvc;
  logic       w_start;     // IDLE may begin a new instruction
  logic       w_continue;  // WRITE may chain straight into the next FETCH
  logic       w_halt_hit;  // jump to the instruction's own address

  // Halt compares the jump target against the PC before it is updated.
  assign w_halt_hit = ~ctl_pcincr & (jump_addr == r_pc);

`ifdef SINGLESTEP_EN
  logic r_step_q;
  logic r_step_run;
  logic w_step_edge;

  assign w_step_edge = step & ~r_step_q;
  assign w_start     = run | w_step_edge;
  // A step-started instruction always drops back to IDLE after WRITE.
  assign w_continue  = run & ~r_step_run;

  // Track step for edge detection and remember how the instruction began.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_step_q   <= 1'b0;
      r_step_run <= 1'b0;
    end else begin
      r_step_q <= step;
      if (r_state == S_IDLE)
        r_step_run <= w_step_edge;
    end
  end
`else
  assign w_start    = run;
  assign w_continue = run;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Next-state decode and phase outputs; strobes exist only in WRITE.
  always_comb begin
    w_next   = r_state;
    rom_en_n = 1'b1;
    a_we     = 1'b0;
    b_we     = 1'b0;
    ram_we   = 1'b0;
    halted   = 1'b0;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_FETCH;
      S_FETCH: w_next = S_EXEC;
      S_EXEC: begin
        rom_en_n = 1'b0;
        w_next   = S_WRITE;
      end
      S_WRITE: begin
        rom_en_n = 1'b0;
        a_we     = ctl_aload;
        b_we     = ctl_bload;
        ram_we   = ctl_ramwrite;
        if (w_halt_hit)
          w_next = S_HALT;
        else if (w_continue)
          w_next = S_FETCH;
        else
          w_next = S_IDLE;
      end
      S_HALT:  halted = 1'b1;
      default: w_next = S_IDLE;
    endcase
  end

  // PC and flags update on the edge that ends WRITE; frozen otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc   <= 8'h00;
      r_nzvc <= 4'h0;
    end else if (r_state == S_WRITE) begin
      r_pc <= ctl_pcincr ? (r_pc + 8'd1) : jump_addr;
      if (ctl_aload | ctl_bload)
        r_nzvc <= alu_nzvc;
    end
  end

  assign PC   = r_pc;
  assign NZVC = r_nzvc;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_sequencer
// Description : Self-checking bench for cpu_sequencer. An instruction-level
//               reference model (PC, flags, halt flag) predicts architectural
//               state; per-phase expectations come from the phase rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       ctl_pcincr;
  logic       ctl_aload;
  logic       ctl_bload;
  logic       ctl_ramwrite;
  logic [7:0] jump_addr;
  logic [3:0] alu_nzvc;
  logic [7:0] PC;
  logic [3:0] NZVC;
  logic       rom_en_n;
  logic       a_we;
  logic       b_we;
  logic       ram_we;
  logic       halted;
`ifdef SINGLESTEP_EN
  logic       step = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] m_pc;
  logic [3:0] m_nzvc;
  logic       m_halt;

  always #5 clk = ~clk;

  cpu_sequencer u_dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
`ifdef SINGLESTEP_EN
    .step         (step),
`endif
    .ctl_pcincr   (ctl_pcincr),
    .ctl_aload    (ctl_aload),
    .ctl_bload    (ctl_bload),
    .ctl_ramwrite (ctl_ramwrite),
    .jump_addr    (jump_addr),
    .alu_nzvc     (alu_nzvc),
    .PC           (PC),
    .NZVC         (NZVC),
    .rom_en_n     (rom_en_n),
    .a_we         (a_we),
    .b_we         (b_we),
    .ram_we       (ram_we),
    .halted       (halted)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Random control values outside WRITE must never reach the strobes.
  task automatic drive_garbage();
    ctl_pcincr   = 1'($urandom);
    ctl_aload    = 1'($urandom);
    ctl_bload    = 1'($urandom);
    ctl_ramwrite = 1'($urandom);
    jump_addr    = 8'($urandom);
    alu_nzvc     = 4'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, check reset values, confirm IDLE holds; optionally start running
  // so that the DUT is in FETCH on return.
  task automatic start_from_reset(input bit go);
    reset = 1'b1;
    run   = 1'b0;
    drive_garbage();
    #1;
    m_pc = 8'h00; m_nzvc = 4'h0; m_halt = 1'b0;
    check_eq("rst_pc",     32'(PC),       32'(m_pc));
    check_eq("rst_nzvc",   32'(NZVC),     32'(m_nzvc));
    check_eq("rst_rom",    32'(rom_en_n), 32'd1);
    check_eq("rst_strobe", 32'({a_we, b_we, ram_we}), 32'd0);
    check_eq("rst_halt",   32'(halted),   32'd0);
    tick();
    reset = 1'b0;
    tick();
    #1;
    check_eq("idle_rom", 32'(rom_en_n), 32'd1);
    check_eq("idle_pc",  32'(PC),       32'(m_pc));
    if (go) begin
      run = 1'b1;
      tick();
    end
  endtask

  // One instruction, entered while the DUT is in FETCH.
  task automatic run_instr(input logic pcincr, input logic aload, input logic bload,
                           input logic ramw, input logic [7:0] ja, input logic [3:0] nz,
                           input logic keep_run);
    drive_garbage();
    #1;
    check_eq("fetch_rom",    32'(rom_en_n), 32'd1);
    check_eq("fetch_strobe", 32'({a_we, b_we, ram_we}), 32'd0);
    check_eq("fetch_pc",     32'(PC),       32'(m_pc));
    check_eq("fetch_nzvc",   32'(NZVC),     32'(m_nzvc));
    tick();
    run = keep_run;
    drive_garbage();
    #1;
    check_eq("exec_rom",    32'(rom_en_n), 32'd0);
    check_eq("exec_strobe", 32'({a_we, b_we, ram_we}), 32'd0);
    tick();
    ctl_pcincr = pcincr; ctl_aload = aload; ctl_bload = bload;
    ctl_ramwrite = ramw; jump_addr = ja; alu_nzvc = nz;
    #1;
    check_eq("write_rom",    32'(rom_en_n), 32'd0);
    check_eq("write_strobe", 32'({a_we, b_we, ram_we}), 32'({aload, bload, ramw}));
    tick();
    if (!pcincr && ja == m_pc) m_halt = 1'b1;
    m_pc = pcincr ? m_pc + 8'd1 : ja;
    if (aload || bload) m_nzvc = nz;
    #1;
    check_eq("post_pc",     32'(PC),       32'(m_pc));
    check_eq("post_nzvc",   32'(NZVC),     32'(m_nzvc));
    check_eq("post_halt",   32'(halted),   32'(m_halt));
    check_eq("post_rom",    32'(rom_en_n), 32'd1);
    check_eq("post_strobe", 32'({a_we, b_we, ram_we}), 32'd0);
  endtask

  // DUT should be parked in IDLE with run low; confirm, then resume.
  task automatic idle_then_resume();
    for (int i = 0; i < 2; i++) begin
      tick();
      drive_garbage();
      #1;
      check_eq("idle_hold_rom", 32'(rom_en_n), 32'd1);
      check_eq("idle_hold_pc",  32'(PC),       32'(m_pc));
    end
    run = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic pi, al, bl, rw, kr;
    logic [7:0] ja;
    int rom_low;

    // Sequential fetch with no control activity
    start_from_reset(1'b1);
    for (int i = 0; i < 4; i++) run_instr(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
    // PC=4: increment with flag load 0100, then PC=5 jump to 0x20, flags hold
    run_instr(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0100, 1'b1);
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 4'b1111, 1'b1);
    // Flag load then flag hold
    run_instr(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'b1010, 1'b1);
    run_instr(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'b1111, 1'b1);
    // Jump to 0xFF, wrap to 0x00, then drop run during EXEC
    run_instr(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 4'h0, 1'b1);
    run_instr(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0110, 1'b1);
    run_instr(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
    idle_then_resume();
    // Jump with simultaneous flag load, then jump-to-self halt at 0x10
    run_instr(1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 4'b0011, 1'b1);
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 4'b1000, 1'b1);
    for (int i = 0; i < 6; i++) begin
      run = 1'($urandom);
      drive_garbage();
      tick();
      check_eq("halt_hold",   32'(halted),   32'd1);
      check_eq("halt_rom",    32'(rom_en_n), 32'd1);
      check_eq("halt_strobe", 32'({a_we, b_we, ram_we}), 32'd0);
      check_eq("halt_pc",     32'(PC),       32'h10);
    end
    // Asynchronous reset out of HALT, away from any clock edge
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("async_rst_pc",   32'(PC),     32'h00);
    check_eq("async_rst_halt", 32'(halted), 32'd0);

    // Reset in the middle of a WRITE with ramwrite asserted
    start_from_reset(1'b1);
    run_instr(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
    tick();
    tick();
    ctl_pcincr = 1'b1; ctl_aload = 1'b0; ctl_bload = 1'b0; ctl_ramwrite = 1'b1;
    #1;
    check_eq("midw_ram_we_before", 32'(ram_we), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("midw_ram_we_after", 32'(ram_we),   32'd0);
    check_eq("midw_rom",          32'(rom_en_n), 32'd1);
    check_eq("midw_pc",           32'(PC),       32'h00);

    // Randomized instruction stream against the model
    start_from_reset(1'b1);
    for (int i = 0; i < 60; i++) begin
      pi = 1'($urandom); al = 1'($urandom); bl = 1'($urandom); rw = 1'($urandom);
      ja = 8'($urandom);
      kr = ($urandom_range(0, 3) != 0);
      run_instr(pi, al, bl, rw, ja, 4'($urandom), kr);
      if (m_halt) start_from_reset(1'b1);
      else if (!kr) idle_then_resume();
    end

`ifdef SINGLESTEP_EN
    // Held step gives exactly one instruction; a second pulse gives one more
    start_from_reset(1'b0);
    ctl_pcincr = 1'b1; ctl_aload = 1'b0; ctl_bload = 1'b0; ctl_ramwrite = 1'b0;
    step = 1'b1;
    rom_low = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rom_en_n == 1'b0) rom_low++;
    end
    check_eq("step_held_rom_cycles", 32'(rom_low), 32'd2);
    check_eq("step_held_pc",         32'(PC),      32'h01);
    step = 1'b0;
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    rom_low = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rom_en_n == 1'b0) rom_low++;
    end
    check_eq("step_pulse_rom_cycles", 32'(rom_low), 32'd2);
    check_eq("step_pulse_pc",         32'(PC),      32'h02);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_sequencer.md
# cpu_sequencer

Phase sequencer for the CSCv2 ROM-decoded datapath. It owns the program counter and the NZVC flags register. It steps each instruction through fetch, execute and write phases, driving the active-low enable of the top control ROM. It gates the ROM's control outputs into single-cycle write strobes and detects the jump-to-self halt idiom.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- run  in  1  level; allows instructions to start
- ctl_pcincr  in  1  top ROM PCincr; 1 = PC+1, 0 = load jump_addr
- ctl_aload  in  1  top ROM Aload
- ctl_bload  in  1  top ROM Bload
- ctl_ramwrite  in  1  top ROM RAMwrite
- jump_addr  in  8  branch target from instruction immediate
- alu_nzvc  in  4  ALU flag outputs {N,Z,V,C}
- PC  out  8  program counter (registered)
- NZVC  out  4  flags register (registered); feeds top ROM address bits 11:8
- rom_en_n  out  1  top ROM enable, active low
- a_we  out  1  A register load strobe
- b_we  out  1  B register load strobe
- ram_we  out  1  RAM write strobe
- halted  out  1  sticky halt indicator

## Operation
- FSM states: IDLE, FETCH, EXEC, WRITE, HALT.
- Reset: state=IDLE, PC=8'h00, NZVC=4'h0, rom_en_n=1, a_we=b_we=ram_we=0, halted=0.
- IDLE: rom_en_n=1. Go to FETCH when run=1, else stay.
- FETCH: rom_en_n=1. The instruction ROM settles on PC. Always go to EXEC.
- EXEC: rom_en_n=0. Control outputs settle. Always go to WRITE.
- WRITE: rom_en_n=0. Strobes are combinational from the state: a_we=ctl_aload, b_we=ctl_bload, ram_we=ctl_ramwrite. Strobes are 0 in every other state.
- At the clock edge ending WRITE:
  - PC <= ctl_pcincr ? PC+1 : jump_addr.
  - If ctl_aload or ctl_bload, NZVC <= alu_nzvc; otherwise NZVC holds.
- Next state after WRITE:
  - ctl_pcincr=0 and jump_addr==PC → HALT.
  - Otherwise run=1 → FETCH, else IDLE.
- HALT: halted=1, rom_en_n=1, strobes 0, PC/NZVC frozen. Only reset exits HALT.
- ctl_* inputs are undriven (Z) while rom_en_n=1. The block samples them only in WRITE.
- PC arithmetic is 8-bit modulo: 8'hFF+1 → 8'h00.

## Timing
- Three clocks per instruction (FETCH, EXEC, WRITE). Back-to-back instructions run with no gap while run=1.
- Start: run sampled high in IDLE → FETCH on the next edge.
- run deasserted mid-instruction: the current instruction completes through WRITE, then the FSM enters IDLE. No partial instruction is possible.
- Updated PC and NZVC are visible in the cycle after WRITE, i.e. in the next FETCH or IDLE.
- Halt detection compares against the pre-update PC. halted rises in the cycle after WRITE.
- Reset during any state acts immediately and asynchronously. Strobes drop in the same cycle with no clock required.
- Simultaneous jump and flag load in one WRITE: both take effect on the same edge.

## Configuration
- SINGLESTEP_EN defined:
  - Adds input port step (1 bit) and a registered copy of it for edge detection.
  - IDLE → FETCH also on a step rising edge (step=1 while the registered copy is 0), whatever the value of run.
  - An instruction started by step always returns to IDLE after WRITE, even if run=1.
  - One step pulse executes exactly one instruction. A step held high gives only one instruction.
  - A step edge in any state other than IDLE is ignored.
- SINGLESTEP_EN undefined: no step port and no edge-detect logic. Behaviour is exactly as in Operation.

## Test plan
- Reset, run=1, ctl_pcincr=1 constant → PC reads 0,1,2,3 at 3-cycle intervals. rom_en_n pattern is 1,0,0 per instruction. No strobes while ctl_* = 0.
- At PC=8'h05, ctl_pcincr=0, jump_addr=8'h20, aload=bload=0, NZVC=4'b0100 → PC=8'h20 after WRITE, NZVC stays 4'b0100.
- WRITE with ctl_aload=1, alu_nzvc=4'b1010 → a_we=1 for exactly one cycle, NZVC=4'b1010. Next WRITE with aload=bload=0, alu_nzvc=4'b1111 → NZVC stays 4'b1010.
- At PC=8'h10, ctl_pcincr=0, jump_addr=8'h10 → halted=1 one cycle later, rom_en_n=1. It remains halted through run toggling until reset, then PC=8'h00 and halted=0.
- Wrap: PC=8'hFF with ctl_pcincr=1 → PC=8'h00. Drop run during EXEC → the instruction completes, then IDLE with rom_en_n=1.
- Reset asserted mid-WRITE with ctl_ramwrite=1 → ram_we=0 in the same cycle, PC=8'h00, state IDLE. With SINGLESTEP_EN defined, run=0 and one step pulse → exactly one PC increment, then IDLE.
